xor_nor_scheduler: RTL and testbench
====================================

XOR_NOR_SCHEDULER -- requirements
Module: xor_nor_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits; legal range WIDTH >= 2.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have ports req0_valid and req1_valid, input, 1 each: requester N presents operands.
REQ-005 SHALL have ports req0_a, req0_b, req1_a and req1_b, input, WIDTH each: operands of requester N.
REQ-006 SHALL have ports req0_ready and req1_ready, output, 1 each: operands of requester N accepted this cycle.
REQ-007 SHALL have port rsp_valid, output, 1: response available.
REQ-008 SHALL have port rsp_ready, input, 1: consumer accepts the response.
REQ-009 SHALL have port rsp_y, output, WIDTH: bitwise a XOR b.
REQ-010 SHALL have port rsp_parity, output, 1: XOR-reduction of rsp_y.
REQ-011 SHALL have port rsp_id, output, 1: index of the requester that produced the response.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-013 SHALL time-share exactly one 1-bit NOR-only XOR cell between both requesters, computing results bit-serially, LSB first.
REQ-014 SHALL implement FSM states IDLE, COMPUTE and RESPOND.
REQ-015 In IDLE with exactly one valid asserted, SHALL assert that requester's ready combinationally in the same cycle.
REQ-016 In IDLE with both valids asserted, SHALL grant the requester that was not granted last (round-robin); the other ready SHALL stay low.
REQ-017 On a valid&&ready handshake, SHALL latch a, b and the id, clear the bit counter and parity, and enter COMPUTE.
REQ-018 Both readys SHALL be low in COMPUTE and RESPOND, so at most one transaction is in flight.
REQ-019 Each COMPUTE cycle SHALL drive a[cnt] and b[cnt] into the cell, write the cell output to y[cnt], XOR it into parity, and increment cnt.
REQ-020 When cnt == WIDTH-1, SHALL write the final bit and enter RESPOND; cnt SHALL never exceed WIDTH-1 (wrap to 0 at the next accept).
REQ-021 With a handshake in cycle T, rsp_valid SHALL first be high in cycle T+WIDTH+1.
REQ-022 rsp_y, rsp_parity and rsp_id SHALL be registered and held stable while rsp_valid && !rsp_ready.
REQ-023 On rsp_valid && rsp_ready, SHALL deassert rsp_valid the next cycle, update the round-robin pointer to rsp_id, and return to IDLE.
REQ-024 Requester valids arriving during COMPUTE or RESPOND SHALL be held by the requester and arbitrated on return to IDLE; minimum period is WIDTH+2 cycles per transaction.
REQ-025 Requester operand changes after a handshake SHALL NOT affect the result in flight.

Reset
REQ-026 With rst high at a clock edge, SHALL enter IDLE and set rsp_valid, rsp_y, rsp_parity, rsp_id, busy and cnt to 0.
REQ-027 After reset, the round-robin pointer SHALL favour requester 0 on the first simultaneous request.
REQ-028 Reset during COMPUTE or RESPOND SHALL abort the transaction; the result SHALL be discarded and no response emitted.

Structure
REQ-029 Package xor_nor_pkg SHALL hold the FSM state enum and the default-WIDTH constant.
REQ-030 The 1-bit XOR SHALL be sub-module nor_xor_bit, built only from 2-input NOR functions (five NORs), instantiated exactly once.
REQ-031 The bit counter SHALL be $clog2(WIDTH) bits wide.

Verification (WIDTH=8)
REQ-032 req0 a=0xA5, b=0x0F -> rsp_y=0xAA, parity=0, id=0, rsp_valid exactly 9 cycles after the handshake.
REQ-033 Both valid after reset (req0 0x01/0x00, req1 0x3C/0x3C) -> first response id=0, y=0x01, parity=1; then id=1, y=0x00, parity=0.
REQ-034 rsp_ready held low 5 cycles in RESPOND -> rsp_valid, rsp_y, rsp_parity and rsp_id stable, and both readys low, throughout.
REQ-035 rst pulsed at cnt=3 of a req1 transaction -> next cycle all outputs 0 and IDLE; that transaction produces no response; a following simultaneous request grants req0.
REQ-036 Both valids held continuously for 6 transactions -> rsp_id sequence 0,1,0,1,0,1.
REQ-037 Cell truth table exercised through operands 0x00/0x00, 0x00/0xFF, 0xFF/0x00, 0xFF/0xFF -> rsp_y 0x00, 0xFF, 0xFF, 0x00; parity 0 in every case.

Source files
------------

// File: rtl/xor_nor_pkg.sv
// Shared types for the bit-serial XOR scheduler.
// Holds the FSM state encoding and the default operand width.
package xor_nor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    RESPOND
  } state_t;

endpackage

// File: rtl/nor_xor_bit.sv
// One-bit XOR assembled from five 2-input NOR gates.
// Shared by both requesters through the scheduler.
module nor_xor_bit (
  input  logic a,
  input  logic b,
  output logic y
);

  logic n1;
  logic n2;
  logic n3;
  logic n4;

  assign n1 = ~(a | b);
  assign n2 = ~(a | n1);
  assign n3 = ~(b | n1);
  // n4 is XNOR; the last NOR acts as an inverter
  assign n4 = ~(n2 | n3);
  assign y  = ~(n4 | n4);

endmodule

// File: rtl/xor_nor_scheduler.sv
// Two-requester round-robin scheduler feeding one bit-serial
// NOR-built XOR cell; one transaction in flight at a time.
import xor_nor_pkg::*;

module xor_nor_scheduler #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_parity,
  output logic             rsp_id,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] y_n;
  logic [CW-1:0]    cnt;
  logic             par_q;
  logic             par_n;
  logic             id_q;
  logic             rr_last;
  logic             cell_a;
  logic             cell_b;
  logic             cell_y;
  logic             last_bit;
  logic             accept;

  assign cell_a   = a_q[cnt];
  assign cell_b   = b_q[cnt];
  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign accept   = req0_ready | req1_ready;
  assign busy     = (state != IDLE);

  nor_xor_bit u_cell (
    .a (cell_a),
    .b (cell_b),
    .y (cell_y)
  );

  always_comb begin
    y_n        = y_q;
    y_n[cnt]   = cell_y;
    par_n      = par_q ^ cell_y;
    state_n    = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state)
      IDLE: begin
        // rr_last holds the id served last; favour the other one
        req0_ready = req0_valid & (~req1_valid | rr_last);
        req1_ready = req1_valid & (~req0_valid | ~rr_last);
        if (req0_ready | req1_ready)
          state_n = COMPUTE;
      end
      COMPUTE: begin
        if (last_bit)
          state_n = RESPOND;
      end
      RESPOND: begin
        if (rsp_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      y_q        <= '0;
      par_q      <= 1'b0;
      id_q       <= 1'b0;
      rr_last    <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_y      <= '0;
      rsp_parity <= 1'b0;
      rsp_id     <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= req1_ready ? req1_a : req0_a;
            b_q   <= req1_ready ? req1_b : req0_b;
            id_q  <= req1_ready;
            cnt   <= '0;
            par_q <= 1'b0;
            y_q   <= '0;
          end
        end
        COMPUTE: begin
          y_q   <= y_n;
          par_q <= par_n;
          if (last_bit) begin
            rsp_valid  <= 1'b1;
            rsp_y      <= y_n;
            rsp_parity <= par_n;
            rsp_id     <= id_q;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_last   <= rsp_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_nor_scheduler.sv
// Directed bench for xor_nor_scheduler at WIDTH=8.
// Hand-computed vectors, one checking task for all compares.
module tb_xor_nor_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_a = '0;
  logic [7:0] req0_b = '0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_a = '0;
  logic [7:0] req1_b = '0;
  logic       req1_ready;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_y;
  logic       rsp_parity;
  logic       rsp_id;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  xor_nor_scheduler #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_y      (rsp_y),
    .rsp_parity (rsp_parity),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic txn(input string tag, input int exp_id,
                     input logic [7:0] ey, input logic ep,
                     input bit drop, input int stall);
    int k;
    bit got;
    bit bad;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) got = 1'b1;
    end
    chk({tag, "_hs"}, 32'(got), 32'd1);
    if (!got) return;
    chk({tag, "_grant"}, {30'd0, req1_ready, req0_ready},
        (exp_id == 1) ? 32'd2 : 32'd1);
    @(posedge clk);
    #1;
    if (drop) begin
      // scramble operands to prove the in-flight result is latched
      if (exp_id == 0) begin
        req0_valid = 1'b0; req0_a = 8'h5A; req0_b = 8'h33;
      end else begin
        req1_valid = 1'b0; req1_a = 8'h5A; req1_b = 8'h33;
      end
    end
    k = 0;
    got = 1'b0;
    bad = 1'b0;
    while (!got && k < 30) begin
      @(negedge clk);
      k++;
      if (k == 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (req0_ready || req1_ready) bad = 1'b1;
      if (rsp_valid) got = 1'b1;
    end
    chk({tag, "_lat"}, k, 32'd9);
    chk({tag, "_rdylow"}, 32'(bad), 32'd0);
    chk({tag, "_y"}, 32'(rsp_y), 32'(ey));
    chk({tag, "_par"}, 32'(rsp_parity), 32'(ep));
    chk({tag, "_id"}, 32'(rsp_id), exp_id);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, "_hold"},
          {19'd0, rsp_valid, rsp_parity, rsp_id, rsp_y,
           req0_ready, req1_ready},
          {19'd0, 1'b1, ep, exp_id[0], ey, 2'b00});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    #1;
    chk({tag, "_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out", {21'd0, rsp_valid, rsp_y, rsp_parity, rsp_id, busy},
        32'd0);
    chk("rst_rdy", {30'd0, req0_ready, req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    req0_a = 8'hA5; req0_b = 8'h0F; req0_valid = 1'b1;
    txn("basic", 0, 8'hAA, 1'b0, 1'b1, 0);

    req0_a = 8'h00; req0_b = 8'h00; req0_valid = 1'b1;
    txn("tt00", 0, 8'h00, 1'b0, 1'b1, 0);
    req1_a = 8'h00; req1_b = 8'hFF; req1_valid = 1'b1;
    txn("tt01", 1, 8'hFF, 1'b0, 1'b1, 0);
    req0_a = 8'hFF; req0_b = 8'h00; req0_valid = 1'b1;
    txn("tt10", 0, 8'hFF, 1'b0, 1'b1, 0);
    req1_a = 8'hFF; req1_b = 8'hFF; req1_valid = 1'b1;
    txn("tt11", 1, 8'h00, 1'b0, 1'b1, 0);

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req0_a = 8'h01; req0_b = 8'h00; req0_valid = 1'b1;
    req1_a = 8'h3C; req1_b = 8'h3C; req1_valid = 1'b1;
    txn("both_a", 0, 8'h01, 1'b1, 1'b1, 0);
    txn("both_b", 1, 8'h00, 1'b0, 1'b1, 0);

    req0_a = 8'h3C; req0_b = 8'h0F; req0_valid = 1'b1;
    txn("stall", 0, 8'h33, 1'b0, 1'b1, 5);

    // abort a req1 transaction at cnt=3
    req1_a = 8'h12; req1_b = 8'h34; req1_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (req1_ready) seen = 1'b1;
    end
    chk("abort_hs", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_out", {21'd0, rsp_valid, rsp_y, rsp_parity, rsp_id, busy},
        32'd0);
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1'b1;
    end
    rsp_ready = 1'b0;
    chk("abort_norsp", 32'(seen), 32'd0);

    @(posedge clk);
    #1;
    req0_a = 8'hF0; req0_b = 8'h0F; req0_valid = 1'b1;
    req1_a = 8'h07; req1_b = 8'h00; req1_valid = 1'b1;
    for (int t = 0; t < 6; t++) begin
      if (t[0] == 1'b0) txn("rr0", 0, 8'hFF, 1'b0, 1'b0, 0);
      else              txn("rr1", 1, 8'h07, 1'b1, 1'b0, 0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
